// File: rtl/cpu_csr_pkg.sv
// cpu_csr_pkg: CSR addresses, write-op encodings, mstatus/mtvec field positions and the write-op helper
package cpu_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  typedef enum logic [1:0] {WOP_NONE, WOP_WRITE, WOP_SET, WOP_CLEAR} wop_e;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;
  localparam logic MTVEC_DIRECT   = 1'b0;
  localparam logic MTVEC_VECTORED = 1'b1;
  function automatic logic [31:0] csr_op(input logic [31:0] old, input logic [31:0] d, input logic [1:0] op);
    return op == WOP_SET ? (old | d) : op == WOP_CLEAR ? (old & ~d) : d;
  endfunction
endpackage

// File: rtl/cpu_csr_counter.sv
// cpu_csr_counter: COUNTER_W-bit wrapping counter with separately writable low word and high bits
module cpu_csr_counter #(
  parameter int COUNTER_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [COUNTER_W-1:0] cnt
);
  localparam int H = COUNTER_W - 32;
  logic [COUNTER_W-1:0] nxt;
  assign nxt = cnt + COUNTER_W'(inc);
  // low write replaces the low word and swallows this cycle's increment (and its carry); high write overrides the carry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else begin
      cnt[31:0] <= wr_lo ? wdata : nxt[31:0];
      cnt[COUNTER_W-1:32] <= wr_hi ? wdata[H-1:0] : wr_lo ? cnt[COUNTER_W-1:32] : nxt[COUNTER_W-1:32];
    end
endmodule

// File: rtl/cpu_csr_trap_unit.sv
// cpu_csr_trap_unit: machine-mode CSRs, trap entry/mret state and trap vector; counters gated by CSR_COUNTERS_EN
module cpu_csr_trap_unit
  import cpu_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000,
  parameter int          COUNTER_W   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] raddr,
  output logic [31:0] rdata,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic [1:0]  wop,
  output logic        illegal,
  input  logic        instret,
  input  logic        trap_en,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret_en,
  output logic [31:0] trap_target,
  output logic [31:0] mepc_out,
  output logic        mie_out
);
  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic        r_hit, w_hit, w_bad, wen;
  logic [31:0] wold, wnew, base;
`ifdef CSR_COUNTERS_EN
  logic [COUNTER_W-1:0] mcycle, minstret;
`endif
  function automatic logic [32:0] csr_rd(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:   csr_rd = {1'b1, 19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
      CSR_MTVEC:     csr_rd = {1'b1, mtvec};
      CSR_MSCRATCH:  csr_rd = {1'b1, mscratch};
      CSR_MEPC:      csr_rd = {1'b1, mepc};
      CSR_MCAUSE:    csr_rd = {1'b1, mcause};
      CSR_MTVAL:     csr_rd = {1'b1, mtval};
      CSR_MHARTID:   csr_rd = {1'b1, MHARTID};
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rd = {1'b1, mcycle[31:0]};
      CSR_MINSTRET:  csr_rd = {1'b1, minstret[31:0]};
      CSR_MCYCLEH:   csr_rd = {1'b1, 32'(mcycle[COUNTER_W-1:32])};
      CSR_MINSTRETH: csr_rd = {1'b1, 32'(minstret[COUNTER_W-1:32])};
`endif
      default:       csr_rd = 33'd0;
    endcase
  endfunction
  // decode the read port and fetch the old value of the write target
  always_comb begin
    {r_hit, rdata} = csr_rd(raddr);
    {w_hit, wold}  = csr_rd(waddr);
  end
  assign wnew        = csr_op(wold, wdata, wop);
  assign w_bad       = wop != WOP_NONE && (!w_hit || waddr[11:10] == 2'b11);
  assign illegal     = !r_hit || w_bad;
  assign wen         = wop != WOP_NONE && !w_bad && !trap_en && !mret_en;
  assign base        = {mtvec[31:2], 2'b00};
  assign trap_target = (mtvec[0] == MTVEC_VECTORED && trap_cause[31]) ? base + {trap_cause[29:0], 2'b00} : base;
  assign mepc_out    = mepc;
  assign mie_out     = mie;
  // trap beats mret beats CSR write; lower-priority events are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ~32'h2;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_en) begin
      mepc   <= trap_pc & ~32'h3;
      mcause <= trap_cause;
      mtval  <= trap_val;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_en) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (wen)
      case (waddr)
        CSR_MSTATUS: begin
          mie  <= wnew[MSTATUS_MIE];
          mpie <= wnew[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= wnew & ~32'h2;
        CSR_MSCRATCH: mscratch <= wnew;
        CSR_MEPC:     mepc     <= wnew & ~32'h3;
        CSR_MCAUSE:   mcause   <= wnew;
        CSR_MTVAL:    mtval    <= wnew;
        default: ;
      endcase
`ifdef CSR_COUNTERS_EN
  cpu_csr_counter #(.COUNTER_W(COUNTER_W)) u_mcycle (
    .clk(clk), .rst_n(rst_n), .inc(1'b1),
    .wr_lo(wen && waddr == CSR_MCYCLE), .wr_hi(wen && waddr == CSR_MCYCLEH),
    .wdata(wnew), .cnt(mcycle)
  );
  cpu_csr_counter #(.COUNTER_W(COUNTER_W)) u_minstret (
    .clk(clk), .rst_n(rst_n), .inc(instret),
    .wr_lo(wen && waddr == CSR_MINSTRET), .wr_hi(wen && waddr == CSR_MINSTRETH),
    .wdata(wnew), .cnt(minstret)
  );
`else
  logic unused_ok;
  assign unused_ok = instret & (COUNTER_W > 0);
`endif
endmodule

// File: tb/tb_cpu_csr_trap_unit.sv
// tb_cpu_csr_trap_unit: directed vectors with hand-computed expectations for cpu_csr_trap_unit
module tb_cpu_csr_trap_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] raddr, waddr;
  logic [31:0] rdata, wdata, trap_cause, trap_pc, trap_val, trap_target, mepc_out;
  logic [1:0]  wop;
  logic        illegal, instret, trap_en, mret_en, mie_out;
  int          n_cmp = 0;
  int          n_bad = 0;
  cpu_csr_trap_unit #(.MTVEC_RESET(32'h0000_0103), .MHARTID(32'h0000_0005), .COUNTER_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata),
    .wop(wop), .illegal(illegal), .instret(instret), .trap_en(trap_en), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .mret_en(mret_en), .trap_target(trap_target),
    .mepc_out(mepc_out), .mie_out(mie_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic exp_ill);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
    chk({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
  endtask
  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    waddr = a; wop = op; wdata = d;
    step;
    wop = 2'b00;
  endtask
  initial begin
    rst_n = 1'b0; raddr = 12'h300; waddr = 12'h000; wdata = '0; wop = 2'b00;
    instret = 1'b0; trap_en = 1'b0; mret_en = 1'b0; trap_cause = '0; trap_pc = '0; trap_val = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step;
    rd("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
    chk("rst_mie", 32'(mie_out), 32'd0);
    chk("rst_mepc", mepc_out, 32'd0);
    chk("rst_target", trap_target, 32'h0000_0100);
    rd("rst_mtvec", 12'h305, 32'h0000_0101, 1'b0);
    rd("mhartid", 12'hF14, 32'h0000_0005, 1'b0);
    rd("unimpl_rd", 12'h7B0, 32'h0, 1'b1);
    waddr = 12'h300; wop = 2'b01; wdata = 32'h8; raddr = 12'h300;
    #1 chk("wr_legal_ill", 32'(illegal), 32'd0);
    step; wop = 2'b00;
    chk("mie_set", 32'(mie_out), 32'd1);
    rd("mstatus_w", 12'h300, 32'h0000_1808, 1'b0);
    wr(12'h305, 2'b10, 32'h0000_1001);
    rd("mtvec_set", 12'h305, 32'h0000_1101, 1'b0);
    wr(12'h305, 2'b11, 32'h0000_0001);
    rd("mtvec_clr", 12'h305, 32'h0000_1100, 1'b0);
    waddr = 12'h7B0; wop = 2'b01; wdata = 32'hFFFF_FFFF; raddr = 12'h305;
    #1 chk("wr_unimpl_ill", 32'(illegal), 32'd1);
    step; wop = 2'b00;
    rd("mtvec_kept", 12'h305, 32'h0000_1100, 1'b0);
    wr(12'h300, 2'b01, 32'hFFFF_FFFF);
    rd("mstatus_mask", 12'h300, 32'h0000_1888, 1'b0);
    wr(12'h300, 2'b11, 32'h0000_0080);
    rd("mstatus_clr", 12'h300, 32'h0000_1808, 1'b0);
    wr(12'h305, 2'b01, 32'h8000_0103);
    rd("mtvec_vec", 12'h305, 32'h8000_0101, 1'b0);
    trap_cause = 32'h0000_0007;
    #1 chk("target_exc", trap_target, 32'h8000_0100);
    trap_en = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_0123; trap_val = 32'h0000_DEAD;
    #1 chk("target_irq", trap_target, 32'h8000_011C);
    step; trap_en = 1'b0;
    chk("trap_mepc", mepc_out, 32'h0000_0120);
    chk("trap_mie", 32'(mie_out), 32'd0);
    rd("trap_mstatus", 12'h300, 32'h0000_1880, 1'b0);
    rd("trap_mcause", 12'h342, 32'h8000_0007, 1'b0);
    rd("trap_mtval", 12'h343, 32'h0000_DEAD, 1'b0);
    rd("trap_mepc_rd", 12'h341, 32'h0000_0120, 1'b0);
    mret_en = 1'b1;
    step; mret_en = 1'b0;
    chk("mret_mie", 32'(mie_out), 32'd1);
    rd("mret_mstatus", 12'h300, 32'h0000_1888, 1'b0);
    wr(12'h340, 2'b01, 32'h0000_0055);
    rd("mscratch", 12'h340, 32'h0000_0055, 1'b0);
    trap_en = 1'b1; mret_en = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h0000_0200; trap_val = 32'h0;
    waddr = 12'h340; wop = 2'b01; wdata = 32'h0000_00AA;
    step; trap_en = 1'b0; mret_en = 1'b0; wop = 2'b00;
    rd("prio_mscratch", 12'h340, 32'h0000_0055, 1'b0);
    rd("prio_mstatus", 12'h300, 32'h0000_1880, 1'b0);
    rd("prio_mcause", 12'h342, 32'h0000_0002, 1'b0);
    chk("prio_mepc", mepc_out, 32'h0000_0200);
    mret_en = 1'b1;
    step; mret_en = 1'b0;
    rd("prio_mret", 12'h300, 32'h0000_1888, 1'b0);
    wr(12'h340, 2'b10, 32'h0);
    rd("set_zero", 12'h340, 32'h0000_0055, 1'b0);
    wr(12'h341, 2'b01, 32'h1234_5677);
    rd("mepc_mask", 12'h341, 32'h1234_5674, 1'b0);
    chk("mepc_out", mepc_out, 32'h1234_5674);
    waddr = 12'hF14; wop = 2'b01; wdata = 32'hFFFF_FFFF; raddr = 12'hF14;
    #1 chk("hartid_wr_ill", 32'(illegal), 32'd1);
    step; wop = 2'b00;
    rd("hartid_kept", 12'hF14, 32'h0000_0005, 1'b0);
`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 2'b01, 32'hFFFF_FFFE);
    rd("mcycle_w", 12'hB00, 32'hFFFF_FFFE, 1'b0);
    rd("mcycleh_0", 12'hB80, 32'h0, 1'b0);
    step; step;
    rd("mcycle_wrap", 12'hB00, 32'h0, 1'b0);
    rd("mcycleh_1", 12'hB80, 32'h1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      instret = 1'b1; step;
      instret = 1'b0; step;
    end
    rd("minstret", 12'hB02, 32'h3, 1'b0);
    rd("minstreth", 12'hB82, 32'h0, 1'b0);
`else
    rd("no_cnt_b00", 12'hB00, 32'h0, 1'b1);
    rd("no_cnt_b82", 12'hB82, 32'h0, 1'b1);
`endif
    trap_en = 1'b1; trap_pc = 32'h0000_0444;
    #2 rst_n = 1'b0;
    #1 chk("async_mepc", mepc_out, 32'h0);
    chk("async_mie", 32'(mie_out), 32'd0);
    step; trap_en = 1'b0; rst_n = 1'b1;
    step;
    chk("post_rst_mepc", mepc_out, 32'h0);
    rd("post_rst_mscratch", 12'h340, 32'h0, 1'b0);
    rd("post_rst_mtvec", 12'h305, 32'h0000_0101, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
